// File: rtl/simon_kexp_stream.sv
// Simon key scheduler streaming one round key per cycle over valid/ready.
// Holds only an m-word sliding window; reverse order is produced by pre-rolling then inverting the step.
module simon_kexp_stream #(
   parameter int WORD_WIDTH = 64,
   parameter int KEY_WORDS  = 2,
   parameter int ROUNDS     = 68,
   parameter int Z_SEQ      = 2
) (
   input  logic                            ck,
   input  logic                            nrst,
   input  logic [WORD_WIDTH*KEY_WORDS-1:0] key,
   input  logic                            reverse,
   input  logic                            k_valid,
   output logic                            k_ready,
   input  logic                            abort,
   output logic [WORD_WIDTH-1:0]           rk,
   output logic [$clog2(ROUNDS)-1:0]       rk_index,
   output logic                            rk_valid,
   input  logic                            rk_ready,
   output logic                            rk_last,
   output logic                            busy
);

   localparam int N  = WORD_WIDTH;
   localparam int M  = KEY_WORDS;
   localparam int IW = $clog2(ROUNDS);
   localparam logic [IW-1:0] IDX_LAST = IW'(ROUNDS - 1);
   localparam logic [IW-1:0] PRE_LAST = IW'(ROUNDS - KEY_WORDS - 1);

   // Symbol 0 of each sequence is the MSB of its constant.
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
   localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
   localparam logic [61:0] ZC = (Z_SEQ == 0) ? Z0 : (Z_SEQ == 1) ? Z1 :
                                (Z_SEQ == 2) ? Z2 : (Z_SEQ == 3) ? Z3 : Z4;

   typedef enum logic [1:0] {IDLE, PRE, FWD, REV} state_t;

   state_t        state;
   logic [N-1:0]  w [M];
   logic [N-1:0]  k_next;
   logic [N-1:0]  k_prev;
   logic [IW-1:0] idx_inc;
   logic [IW-1:0] idx_dec;

   function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int r);
      return (x >> r) | (x << (N - r));
   endfunction

   function automatic logic [N-1:0] mix(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] t;
      t = ror(a, 3);
      if (M == 4) t = t ^ b;
      t = t ^ ror(t, 1);
      return t;
   endfunction

   // Round constant 3 ^ z_j[i mod 62]; i never reaches 124.
   function automatic logic [N-1:0] rc(input logic [6:0] i);
      logic [6:0]  k;
      logic [61:0] s;
      logic [N-1:0] c;
      k = (i >= 7'd62) ? i - 7'd62 : i;
      s = ZC << k;
      c = N'(3);
      c[0] = c[0] ^ s[61];
      return c;
   endfunction

   always_comb begin
      idx_inc = rk_index + 1'b1;
      idx_dec = rk_index - 1'b1;
      k_next  = ~w[0] ^ mix(w[M-1], w[1]) ^ rc(7'(rk_index));
      k_prev  = ~(w[M-1] ^ mix(w[M-2], w[0]) ^ rc(7'(rk_index) - 7'(M)));
   end

   always_ff @(posedge ck) begin
      if (!nrst) begin
         state    <= IDLE;
         for (int i = 0; i < M; i++) w[i] <= '0;
         rk       <= '0;
         rk_index <= '0;
         rk_valid <= 1'b0;
         rk_last  <= 1'b0;
         k_ready  <= 1'b1;
         busy     <= 1'b0;
      end else if (abort && state != IDLE) begin
         state    <= IDLE;
         rk_valid <= 1'b0;
         rk_last  <= 1'b0;
         k_ready  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (k_valid) begin
               for (int i = 0; i < M; i++) w[i] <= key[i*N +: N];
               rk_index <= '0;
               rk_last  <= 1'b0;
               k_ready  <= 1'b0;
               busy     <= 1'b1;
               if (reverse) begin
                  state    <= PRE;
                  rk_valid <= 1'b0;
               end else begin
                  state    <= FWD;
                  rk       <= key[N-1:0];
                  rk_valid <= 1'b1;
               end
            end
            // Silent roll-forward; the final step lands k(T-1) in the top word.
            PRE: begin
               for (int i = 0; i < M - 1; i++) w[i] <= w[i+1];
               w[M-1] <= k_next;
               if (rk_index == PRE_LAST) begin
                  state    <= REV;
                  rk       <= k_next;
                  rk_index <= IDX_LAST;
                  rk_valid <= 1'b1;
               end else begin
                  rk_index <= idx_inc;
               end
            end
            FWD: if (rk_ready) begin
               if (rk_index == IDX_LAST) begin
                  state    <= IDLE;
                  rk_valid <= 1'b0;
                  rk_last  <= 1'b0;
                  k_ready  <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  for (int i = 0; i < M - 1; i++) w[i] <= w[i+1];
                  w[M-1]   <= k_next;
                  rk       <= w[1];
                  rk_index <= idx_inc;
                  rk_last  <= (idx_inc == IDX_LAST);
               end
            end
            // Below index m the original key words are already in the window.
            REV: if (rk_ready) begin
               if (rk_index == '0) begin
                  state    <= IDLE;
                  rk_valid <= 1'b0;
                  rk_last  <= 1'b0;
                  k_ready  <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  for (int i = 1; i < M; i++) w[i] <= w[i-1];
                  w[0]     <= (rk_index >= IW'(M)) ? k_prev : '0;
                  rk       <= w[M-2];
                  rk_index <= idx_dec;
                  rk_last  <= (idx_dec == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simon_kexp_stream.sv
// Bench for simon_kexp_stream: all ten Simon configurations side by side, each checked
// against a full expanded-key array built from the textbook recurrence.
module tb_simon_kexp_stream;

   localparam int ND = 10;
   localparam int CN [ND] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
   localparam int CM [ND] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};
   localparam int CT [ND] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
   localparam int CJ [ND] = '{ 0,  0,  1,  2,  3,  2,  3,  2,  3,  4};

   string zs [5] = '{
      "11111010001001010110000111001101111101000100101011000011100110",
      "10001110111110010011000010110101000111011111001001100001011010",
      "10101111011100000011010010011000101000010001111110010110110011",
      "11011011101011000110010111100000010010001010011100110100001111",
      "11010001111001101011011000100000010111000011001010010011101111"};

   logic ck = 1'b0;
   logic nrst;
   always #5 ck = ~ck;

   logic [255:0] key_s [ND];
   logic         rev_s [ND];
   logic         kv_s  [ND];
   logic         ab_s  [ND];
   logic         rr_s  [ND];
   wire  [63:0]  rk_s  [ND];
   wire  [6:0]   ix_s  [ND];
   wire          rv_s  [ND];
   wire          rl_s  [ND];
   wire          kr_s  [ND];
   wire          bz_s  [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int N  = CN[g];
      localparam int M  = CM[g];
      localparam int IW = $clog2(CT[g]);
      logic [N-1:0]  rk_w;
      logic [IW-1:0] ix_w;
      logic          rv_w, rl_w, kr_w, bz_w;
      simon_kexp_stream #(.WORD_WIDTH(N), .KEY_WORDS(M), .ROUNDS(CT[g]), .Z_SEQ(CJ[g])) dut (
         .ck(ck), .nrst(nrst), .key(key_s[g][N*M-1:0]), .reverse(rev_s[g]),
         .k_valid(kv_s[g]), .k_ready(kr_w), .abort(ab_s[g]), .rk(rk_w),
         .rk_index(ix_w), .rk_valid(rv_w), .rk_ready(rr_s[g]), .rk_last(rl_w), .busy(bz_w));
      assign rk_s[g] = 64'(rk_w);
      assign ix_s[g] = 7'(ix_w);
      assign rv_s[g] = rv_w;
      assign rl_s[g] = rl_w;
      assign kr_s[g] = kr_w;
      assign bz_s[g] = bz_w;
   end

   int vecs = 0;
   int errs = 0;
   logic [63:0] ek [72];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ror_n(input logic [63:0] x, input int r, input int n);
      logic [63:0] mask;
      mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      return ((x >> r) | (x << (n - r))) & mask;
   endfunction

   function automatic logic [255:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Expanded key k0..kT-1 straight from the Simon key-schedule recurrence.
   task automatic gold(input int g, input logic [255:0] key);
      int n, m, t, j;
      logic [63:0] mask, tmp;
      bit zb;
      n = CN[g]; m = CM[g]; t = CT[g]; j = CJ[g];
      mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      for (int i = 0; i < t; i++) begin
         if (i < m) begin
            ek[i] = 64'(key >> (i * n)) & mask;
         end else begin
            tmp = ror_n(ek[i-1], 3, n);
            if (m == 4) tmp = tmp ^ ek[i-3];
            tmp = tmp ^ ror_n(tmp, 1, n);
            zb = (zs[j][(i - m) % 62] == "1");
            ek[i] = (~ek[i-m] ^ tmp ^ 64'(zb) ^ 64'd3) & mask;
         end
      end
   endtask

   task automatic run(input int g, input bit rv, input logic [255:0] key,
                      input int stall, input int abort_at, input bit noise);
      int m, t, pos, lat, cyc, e;
      bit seen;
      m = CM[g]; t = CT[g]; pos = 0; seen = 0;
      gold(g, key);
      @(negedge ck);
      cyc = 0;
      while (!kr_s[g] && cyc < 200) begin @(negedge ck); cyc++; end
      chk("k_ready_idle", 64'(kr_s[g]), 64'd1);
      key_s[g] = key; rev_s[g] = rv; kv_s[g] = 1'b1; rr_s[g] = 1'b0;
      @(negedge ck);
      lat = 1;
      chk("busy_after_accept", 64'(bz_s[g]), 64'd1);
      chk("k_ready_after_accept", 64'(kr_s[g]), 64'd0);
      kv_s[g] = noise;
      if (noise) key_s[g] = rand_key();
      cyc = 0;
      while (pos < t && cyc < 600) begin
         if (rv_s[g]) begin
            e = rv ? t - 1 - pos : pos;
            if (!seen) begin
               chk("latency", 64'(lat), 64'(rv ? t - m + 1 : 1));
               seen = 1;
            end
            chk("rk", rk_s[g], ek[e]);
            chk("rk_index", 64'(ix_s[g]), 64'(e));
            chk("rk_last", 64'(rl_s[g]), 64'(pos == t - 1));
            if (pos == abort_at) begin
               ab_s[g] = 1'b1; rr_s[g] = 1'b1;
               @(negedge ck);
               ab_s[g] = 1'b0; rr_s[g] = 1'b0; kv_s[g] = 1'b0;
               chk("abort_rk_valid", 64'(rv_s[g]), 64'd0);
               chk("abort_k_ready", 64'(kr_s[g]), 64'd1);
               chk("abort_busy", 64'(bz_s[g]), 64'd0);
               return;
            end
            rr_s[g] = ($urandom_range(99) >= stall);
            if (rr_s[g]) pos++;
         end else begin
            rr_s[g] = 1'($urandom_range(1));
         end
         @(negedge ck);
         lat++; cyc++;
      end
      kv_s[g] = 1'b0; rr_s[g] = 1'b0;
      chk("stream_complete", 64'(pos), 64'(t));
      chk("done_k_ready", 64'(kr_s[g]), 64'd1);
      chk("done_rk_valid", 64'(rv_s[g]), 64'd0);
      chk("done_busy", 64'(bz_s[g]), 64'd0);
      @(negedge ck);
      chk("no_accept_on_last", 64'(kr_s[g]), 64'd1);
   endtask

   task automatic check_reset(input int g);
      chk("rst_k_ready", 64'(kr_s[g]), 64'd1);
      chk("rst_rk_valid", 64'(rv_s[g]), 64'd0);
      chk("rst_rk", rk_s[g], 64'd0);
      chk("rst_rk_index", 64'(ix_s[g]), 64'd0);
      chk("rst_rk_last", 64'(rl_s[g]), 64'd0);
      chk("rst_busy", 64'(bz_s[g]), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] k;
      nrst = 1'b0;
      for (int g = 0; g < ND; g++) begin
         key_s[g] = '0; rev_s[g] = 1'b0; kv_s[g] = 1'b0; ab_s[g] = 1'b0; rr_s[g] = 1'b0;
      end
      repeat (3) @(negedge ck);
      for (int g = 0; g < ND; g++) check_reset(g);
      nrst = 1'b1;

      // Simon32/64 forward at full throughput.
      run(0, 1'b0, 256'h1918_1110_0908_0100, 0, -1, 1'b0);
      // Simon128/128 reverse.
      run(7, 1'b1, 256'h0f0e0d0c0b0a0908_0706050403020100, 0, -1, 1'b0);
      // Simon64/128 forward with consumer stalls.
      run(4, 1'b0, 256'h1b1a1918_13121110_0b0a0908_03020100, 40, -1, 1'b0);
      // Abort mid-stream, then a fresh schedule from k0.
      run(0, 1'b0, rand_key(), 20, 10, 1'b0);
      run(0, 1'b0, rand_key(), 0, -1, 1'b0);

      // Reset while pre-rolling a reverse schedule, with k_valid held high throughout.
      @(negedge ck);
      key_s[7] = rand_key(); rev_s[7] = 1'b1; kv_s[7] = 1'b1;
      repeat (10) @(negedge ck);
      chk("pre_rk_valid", 64'(rv_s[7]), 64'd0);
      chk("pre_busy", 64'(bz_s[7]), 64'd1);
      nrst = 1'b0;
      @(negedge ck);
      check_reset(7);
      nrst = 1'b1; kv_s[7] = 1'b0;
      run(7, 1'b1, rand_key(), 10, -1, 1'b1);

      // Every configuration, same key forward then reverse.
      for (int g = 0; g < ND; g++) begin
         k = rand_key();
         run(g, 1'b0, k, 25, -1, 1'(g % 2));
         run(g, 1'b1, k, 25, -1, 1'((g + 1) % 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
